// File: rtl/note_display_pkg.sv
// Shared types, glyphs and the frequency-to-note decoder for the note display.
// Segment glyphs are active-low, ordered {g,f,e,d,c,b,a}.
package note_display_pkg;

    typedef enum logic [2:0] {LtrC, LtrD, LtrE, LtrF, LtrG, LtrA, LtrB} letter_e;

    typedef struct packed {
        logic       valid;
        letter_e    letter;
        logic       sharp;
        logic [3:0] octave;
    } note_t;

    localparam note_t NOTE_INVALID = '{valid: 1'b0, letter: LtrC, sharp: 1'b0, octave: 4'd0};

    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_G     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_SHARP = 7'b0001001;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam int unsigned NUM_NOTES = 36;

    // Octaves 3..5, twelve semitones each starting at C.
    localparam int unsigned FREQ_TABLE [NUM_NOTES] = '{
        131, 139, 147, 156, 165, 175, 185, 196, 208, 220, 233, 247,
        261, 277, 293, 311, 330, 349, 370, 392, 415, 440, 466, 494,
        523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988
    };

    function automatic letter_e semitone_letter(input int unsigned semi);
        case (semi)
            0, 1:    return LtrC;
            2, 3:    return LtrD;
            4:       return LtrE;
            5, 6:    return LtrF;
            7, 8:    return LtrG;
            9, 10:   return LtrA;
            default: return LtrB;
        endcase
    endfunction

    function automatic note_t freq_to_note(input int unsigned f);
        note_t n;
        n = NOTE_INVALID;
        for (int unsigned i = 0; i < NUM_NOTES; i++) begin
            if (f == FREQ_TABLE[i]) begin
                n.valid  = 1'b1;
                n.letter = semitone_letter(i % 12);
                n.sharp  = (i % 12) inside {1, 3, 6, 8, 10};
                n.octave = 4'(3 + i / 12);
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] letter_glyph(input letter_e l);
        case (l)
            LtrC:    return GLYPH_C;
            LtrD:    return GLYPH_D;
            LtrE:    return GLYPH_E;
            LtrF:    return GLYPH_F;
            LtrG:    return GLYPH_G;
            LtrA:    return GLYPH_A;
            LtrB:    return GLYPH_B;
            default: return GLYPH_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] octave_glyph(input logic [3:0] oct);
        case (oct)
            4'd3:    return GLYPH_3;
            4'd4:    return GLYPH_4;
            4'd5:    return GLYPH_5;
            default: return GLYPH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Refresh prescaler and digit-index counter for the multiplexed display.
// frame_start pulses on the tick that wraps the index back to digit 0.
module display_scan_timer #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_tick,
    output logic             o_frame_start,
    output logic [IDX_W-1:0] o_index
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

    logic [PRE_W-1:0] r_presc;
    logic [IDX_W-1:0] r_index;
    logic             w_tick;
    logic             w_last;

    assign w_tick = (r_presc == PRE_W'(REFRESH_DIV - 1));
    assign w_last = (r_index == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
            r_index <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_index <= w_last ? '0 : r_index + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    assign o_tick        = w_tick;
    assign o_frame_start = w_tick && w_last;
    assign o_index       = r_index;

endmodule

// File: rtl/note_display_scan.sv
// Multiplexed 7-segment note display: freq -> {letter, sharp, octave}, scanned over NUM_DIGITS.
// Define NOTE_HOLD_EN to keep the last valid note for HOLD_FRAMES frames after it goes invalid.
module note_display_scan
    import note_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned FREQ_W      = 12,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned HOLD_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FREQ_W-1:0]     freq,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            segOut
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    if (NUM_DIGITS < 3 || NUM_DIGITS > 8 || REFRESH_DIV < 2 || HOLD_FRAMES < 1) begin : g_param_check
        $error("note_display_scan: illegal parameter set");
    end

    logic                  w_tick;
    logic                  w_frame_start;
    logic                  w_boundary;
    logic [IDX_W-1:0]      w_index;
    logic [FREQ_W-1:0]     r_freq;
    note_t                 r_note;
    note_t                 r_disp;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] w_anode;
    logic [6:0]            w_seg;

    display_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_tick        (w_tick),
        .o_frame_start (w_frame_start),
        .o_index       (w_index)
    );

    assign w_boundary = w_tick && w_frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_freq <= '0;
            r_note <= NOTE_INVALID;
        end else begin
            r_freq <= freq;
            r_note <= freq_to_note(32'(r_freq));
        end
    end

`ifdef NOTE_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [HOLD_W-1:0] r_hold;

    // An invalid note only blanks the display once the hold budget is spent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp <= NOTE_INVALID;
            r_hold <= '0;
        end else if (w_boundary) begin
            if (r_note.valid) begin
                r_disp <= r_note;
                r_hold <= '0;
            end else if (r_disp.valid && r_hold < HOLD_W'(HOLD_FRAMES)) begin
                r_hold <= r_hold + HOLD_W'(1);
            end else begin
                r_disp <= NOTE_INVALID;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp <= NOTE_INVALID;
        end else if (w_boundary) begin
            r_disp <= r_note;
        end
    end
`endif

    always_comb begin
        w_seg   = GLYPH_BLANK;
        w_anode = ~(NUM_DIGITS'(1) << w_index);
        if (!r_disp.valid) begin
            if (w_index == IDX_W'(2)) begin
                w_seg = GLYPH_DASH;
            end
        end else begin
            case (w_index)
                IDX_W'(0): w_seg = octave_glyph(r_disp.octave);
                IDX_W'(1): w_seg = r_disp.sharp ? GLYPH_SHARP : GLYPH_BLANK;
                IDX_W'(2): w_seg = letter_glyph(r_disp.letter);
                default:   w_seg = GLYPH_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anode <= '1;
            r_seg   <= GLYPH_BLANK;
        end else begin
            r_anode <= w_anode;
            r_seg   <= w_seg;
        end
    end

    assign anode  = r_anode;
    assign segOut = r_seg;

endmodule

// File: tb/tb_note_display_scan.sv
// Self-checking bench for note_display_scan with a frame-level reference model.
// Exercises the NOTE_HOLD_EN behaviour only when that macro is defined.
module tb_note_display_scan;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int HF = 2;
    localparam int FRAME = ND * RD;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_SHARP = 7'b0001001;
    localparam logic [6:0] S_C     = 7'b1000110;
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S_A     = 7'b0001000;
    localparam logic [6:0] S_B     = 7'b0000011;
    localparam logic [6:0] S_4     = 7'b0011001;
    localparam logic [6:0] S_5     = 7'b0010010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] freq = '0;
    logic [3:0]  anode;
    logic [6:0]  segOut;

    int errors = 0;
    int checks = 0;
    int k = 0;
    int fhist [4096];

    int tbl [36] = '{
        131, 139, 147, 156, 165, 175, 185, 196, 208, 220, 233, 247,
        261, 277, 293, 311, 330, 349, 370, 392, 415, 440, 466, 494,
        523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988
    };
    logic [6:0] semi_glyph [12] = '{
        7'b1000110, 7'b1000110, 7'b0100001, 7'b0100001, 7'b0000110, 7'b0001110,
        7'b0001110, 7'b0010000, 7'b0010000, 7'b0001000, 7'b0001000, 7'b0000011
    };
    bit semi_sharp [12] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0};
    logic [6:0] oct_glyph [3] = '{7'b0110000, 7'b0011001, 7'b0010010};

    note_display_scan #(
        .NUM_DIGITS  (ND),
        .FREQ_W      (12),
        .REFRESH_DIV (RD),
        .HOLD_FRAMES (HF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .freq   (freq),
        .anode  (anode),
        .segOut (segOut)
    );

    always #5 clk = ~clk;

    // k = number of rising edges since reset release; fhist[k] = freq seen at edge k.
    always @(posedge clk) begin
        if (rst) begin
            k <= 0;
        end else begin
            k <= k + 1;
            if (k + 1 < 4096) fhist[k + 1] <= int'(freq);
        end
    end

    function automatic int note_of(input int fr);
        for (int i = 0; i < 36; i++) if (tbl[i] == fr) return i;
        return -1;
    endfunction

    // Displayed note after edge kk: replay every frame boundary (each FRAME edges).
    function automatic int disp_at(input int kk);
        int d = -1;
        int hold = 0;
        int n;
        for (int b = FRAME; b <= kk - 1; b += FRAME) begin
            n = note_of(fhist[b - 2]);
            if (n >= 0) begin
                d = n;
                hold = 0;
            end
`ifdef NOTE_HOLD_EN
            else if (d >= 0 && hold < HF) hold++;
`endif
            else d = -1;
        end
        return d;
    endfunction

    function automatic void model_out(output logic [3:0] ea, output logic [6:0] es);
        int idx;
        int d;
        ea = 4'hF;
        es = S_BLANK;
        if (rst || k == 0) return;
        idx = ((k - 1) / RD) % ND;
        ea[idx] = 1'b0;
        d = disp_at(k);
        if (d < 0) begin
            if (idx == 2) es = S_DASH;
        end else begin
            case (idx)
                0: es = oct_glyph[d / 12];
                1: es = semi_sharp[d % 12] ? S_SHARP : S_BLANK;
                2: es = semi_glyph[d % 12];
                default: es = S_BLANK;
            endcase
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        logic [6:0] es;
        freq = 12'd440;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (anode !== 4'hF || segOut !== S_BLANK) begin
                errors++;
                $display("FAIL reset_hold anode=%b seg=%b want anode=1111 seg=1111111", anode, segOut);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            model_out(ea, es);
            checks++;
            if (anode !== ea || segOut !== es) begin
                errors++;
                $display("FAIL reset_scan k=%0d anode=%b seg=%b want anode=%b seg=%b",
                         k, anode, segOut, ea, es);
            end
            if (k == 1 || k == 20 || k == 24 || k == 28) begin
                ea = (k == 1) ? 4'b1110 : (k == 20) ? 4'b1110 : (k == 24) ? 4'b1101 : 4'b1011;
                es = (k == 1) ? S_BLANK : (k == 20) ? S_4 : (k == 24) ? S_BLANK : S_A;
                checks++;
                if (anode !== ea || segOut !== es) begin
                    errors++;
                    $display("FAIL reset_a440 k=%0d anode=%b seg=%b want anode=%b seg=%b",
                             k, anode, segOut, ea, es);
                end
            end
        end
    endtask

    task automatic test_steady_277();
        logic [3:0] ea;
        logic [6:0] es;
        int lows [4] = '{0, 0, 0, 0};
        freq = 12'd277;
        do_reset();
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            model_out(ea, es);
            checks++;
            if (anode !== ea || segOut !== es) begin
                errors++;
                $display("FAIL steady277 k=%0d anode=%b seg=%b want anode=%b seg=%b",
                         k, anode, segOut, ea, es);
            end
            if (k >= 17 && k <= 48) for (int i = 0; i < 4; i++) if (anode[i] === 1'b0) lows[i]++;
            if (k == 44 || k == 40 || k == 36) begin
                es = (k == 44) ? S_C : (k == 40) ? S_SHARP : S_4;
                checks++;
                if (segOut !== es) begin
                    errors++;
                    $display("FAIL steady277_glyph k=%0d seg=%b want %b", k, segOut, es);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lows[i] != 2 * RD) begin
                errors++;
                $display("FAIL anode_duty digit=%0d low_cycles=%0d want %0d", i, lows[i], 2 * RD);
            end
        end
    endtask

    task automatic test_off_table();
        logic [3:0] ea;
        logic [6:0] es;
        freq = 12'd262;
        do_reset();
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            model_out(ea, es);
            checks++;
            if (anode !== ea || segOut !== es) begin
                errors++;
                $display("FAIL off_table k=%0d anode=%b seg=%b want anode=%b seg=%b",
                         k, anode, segOut, ea, es);
            end
            if (k == 44 || k == 36) begin
                es = (k == 44) ? S_DASH : S_BLANK;
                checks++;
                if (segOut !== es) begin
                    errors++;
                    $display("FAIL off_table_glyph k=%0d seg=%b want %b", k, segOut, es);
                end
            end
        end
    endtask

    task automatic test_mid_frame_change();
        logic [3:0] ea;
        logic [6:0] es;
        freq = 12'd330;
        do_reset();
        for (int c = 0; c < 4 * FRAME; c++) begin
            @(negedge clk);
            model_out(ea, es);
            checks++;
            if (anode !== ea || segOut !== es) begin
                errors++;
                $display("FAIL mid_change k=%0d anode=%b seg=%b want anode=%b seg=%b",
                         k, anode, segOut, ea, es);
            end
            if (k == 40 || k == 44 || k == 52 || k == 56 || k == 60) begin
                es = (k == 40) ? S_BLANK : (k == 44) ? S_E : (k == 52) ? S_5 :
                     (k == 56) ? S_SHARP : S_A;
                checks++;
                if (segOut !== es) begin
                    errors++;
                    $display("FAIL mid_change_glyph k=%0d seg=%b want %b", k, segOut, es);
                end
            end
            if (k == 36) freq = 12'd932;
        end
    endtask

    task automatic test_random();
        logic [3:0] ea;
        logic [6:0] es;
        freq = 12'd0;
        do_reset();
        for (int c = 0; c < 14 * FRAME; c++) begin
            @(negedge clk);
            model_out(ea, es);
            checks++;
            if (anode !== ea || segOut !== es) begin
                errors++;
                $display("FAIL random k=%0d anode=%b seg=%b want anode=%b seg=%b",
                         k, anode, segOut, ea, es);
            end
            if ($urandom_range(0, 1) == 0) freq = 12'(tbl[$urandom_range(0, 35)]);
            else freq = 12'($urandom_range(0, 4095));
        end
    endtask

`ifdef NOTE_HOLD_EN
    task automatic test_hold();
        logic [3:0] ea;
        logic [6:0] es;
        for (int pass = 0; pass < 2; pass++) begin
            freq = 12'd494;
            do_reset();
            for (int c = 0; c < 5 * FRAME; c++) begin
                @(negedge clk);
                model_out(ea, es);
                checks++;
                if (anode !== ea || segOut !== es) begin
                    errors++;
                    $display("FAIL hold%0d k=%0d anode=%b seg=%b want anode=%b seg=%b",
                             pass, k, anode, segOut, ea, es);
                end
                if (k == 44 || k == 60 || k == 76) begin
                    es = (k == 44) ? S_B : (k == 60) ? ((pass == 0) ? S_B : S_C) :
                         ((pass == 0) ? S_DASH : S_C);
                    checks++;
                    if (segOut !== es) begin
                        errors++;
                        $display("FAIL hold%0d_glyph k=%0d seg=%b want %b", pass, k, segOut, es);
                    end
                end
                if (k == 20) freq = 12'd0;
                if (k == 36 && pass == 1) freq = 12'd261;
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [3:0] ea;
        logic [6:0] es;
        freq = 12'd440;
        do_reset();
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            model_out(ea, es);
            checks++;
            if (anode !== ea || segOut !== es) begin
                errors++;
                $display("FAIL pre_rst k=%0d anode=%b seg=%b want anode=%b seg=%b",
                         k, anode, segOut, ea, es);
            end
        end
        checks++;
        if (anode !== 4'b1011) begin
            errors++;
            $display("FAIL pre_rst_index anode=%b want 1011", anode);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (anode !== 4'hF || segOut !== S_BLANK) begin
            errors++;
            $display("FAIL rst_async anode=%b seg=%b want anode=1111 seg=1111111", anode, segOut);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            model_out(ea, es);
            checks++;
            if (anode !== ea || segOut !== es) begin
                errors++;
                $display("FAIL post_rst k=%0d anode=%b seg=%b want anode=%b seg=%b",
                         k, anode, segOut, ea, es);
            end
            if (k == 1 || k == 12) begin
                ea = (k == 1) ? 4'b1110 : 4'b1011;
                es = (k == 1) ? S_BLANK : S_DASH;
                checks++;
                if (anode !== ea || segOut !== es) begin
                    errors++;
                    $display("FAIL restart_invalid k=%0d anode=%b seg=%b want anode=%b seg=%b",
                             k, anode, segOut, ea, es);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady_277();
        test_off_table();
        test_mid_frame_change();
        test_random();
`ifdef NOTE_HOLD_EN
        test_hold();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
